instruction_fetch: RTL and testbench

- Front-end stage directly upstream of the instruction decoder: owns the PC, issues word reads to instruction memory, buffers returned words, and presents {instruction, pc} to decode with a valid/ready handshake.
- Supports multiple requests in flight, memory back-pressure, decode stalls, and redirects from execute (branch/jump). On a redirect it flushes buffered and in-flight stale instructions.

---
 rtl/instruction_fetch.sv | 136 +++++++++++++
 tb/tb_instruction_fetch.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// instruction_fetch: front-end fetch stage that sits directly before the decoder.
// It owns the PC and issues word reads to instruction memory. Returned words are
// buffered, and {inst, inst_pc} is presented to decode with a valid/ready handshake.
// Several requests may be in flight at once. A redirect from execute restarts
// fetch at a new PC and discards every stale word, both buffered and in flight.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   imem_req_valid    fetch request valid (held until accepted)
//   imem_req_ready    memory accepts the request this cycle
//   imem_addr         word-aligned fetch address (always the fetch PC)
//   imem_resp_valid   in-order read data returning, never back-pressured
//   imem_resp_data    returned instruction word
//   redirect_valid    one-cycle pulse: restart fetch at redirect_pc
//   redirect_pc       new PC, low two bits ignored
//   inst_valid        buffer head valid toward decode
//   inst_ready        decode consumes the head this cycle
//   inst, inst_pc     head instruction word and its address
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = CW + 1;
  localparam logic [SW-1:0] LIMIT = SW'(DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   buf_inst [DEPTH];
  logic [31:0]   buf_pc   [DEPTH];
  logic [31:0]   req_pc   [DEPTH];
  logic [PW-1:0] head, tail;
  logic [PW-1:0] req_rd, req_wr;
  logic [CW-1:0] count, outstanding, drop;

  logic [SW-1:0] in_use;
  logic          accept, push, pop;
  logic [31:0]   redirect_target;

  always_comb begin
    imem_addr  = fetch_pc;
    inst_valid = (count != '0);
    inst       = buf_inst[head];
    inst_pc    = buf_pc[head];

    // Every outstanding request owns a buffer slot, so buffered plus in-flight
    // entries never exceed DEPTH and a response always has room.
    in_use         = {1'b0, count} + {1'b0, outstanding};
    imem_req_valid = rst_n && (in_use < LIMIT) && (drop == '0) && !redirect_valid;
    accept         = imem_req_valid && imem_req_ready;
    push           = imem_resp_valid && (drop == '0) && !redirect_valid;
    pop            = inst_valid && inst_ready;

    redirect_target = redirect_pc & 32'hFFFF_FFFC;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      buf_inst    <= '{default: '0};
      buf_pc      <= '{default: '0};
      req_pc      <= '{default: '0};
      head        <= '0;
      tail        <= '0;
      req_rd      <= '0;
      req_wr      <= '0;
      count       <= '0;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      // PC of each accepted request is queued in issue order. Responses return
      // in the same order, so the queue head always names the returning word.
      if (accept) begin
        req_pc[req_wr] <= fetch_pc;
        req_wr         <= req_wr + PW'(1);
      end
      if (imem_resp_valid) begin
        req_rd <= req_rd + PW'(1);
      end

      if (accept && !imem_resp_valid) begin
        outstanding <= outstanding + CW'(1);
      end else if (!accept && imem_resp_valid) begin
        outstanding <= outstanding - CW'(1);
      end

      if (push) begin
        buf_inst[tail] <= imem_resp_data;
        buf_pc[tail]   <= req_pc[req_rd];
        tail           <= tail + PW'(1);
      end
      if (pop) begin
        head <= head + PW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (!push && pop) begin
        count <= count - CW'(1);
      end

      if (imem_resp_valid && (drop != '0)) begin
        drop <= drop - CW'(1);
      end

      if (accept) begin
        fetch_pc <= fetch_pc + 32'd4;
      end

      // Redirect overrides the updates above. Every request still in flight
      // after this cycle's response is stale and must be dropped on return.
      // No push happens this cycle, so head <= tail empties the buffer.
      if (redirect_valid) begin
        fetch_pc <= redirect_target;
        head     <= tail;
        count    <= '0;
        drop     <= imem_resp_valid ? (outstanding - CW'(1)) : outstanding;
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: bench for instruction_fetch. It runs a per-cycle vector
// table, hand sequences for stalls, redirects and reset, and a randomized run.
// A behavioural memory returns addr ^ 32'hA5A5_0000 after a configurable latency.
// The reference model only knows that fetch addresses and decoded PCs advance
// by 4 from the current restart point.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mr, dr, rd;
  logic [31:0] rpc;
  logic        resp_v0, resp_v1;
  logic [31:0] resp_d0, resp_d1;
  logic        rv0, rv1, iv0, iv1;
  logic [31:0] addr0, addr1, inst0, inst1, ipc0, ipc1;

  always #5 clk = ~clk;

  instruction_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(rv0), .imem_req_ready(mr), .imem_addr(addr0),
    .imem_resp_valid(resp_v0), .imem_resp_data(resp_d0),
    .redirect_valid(rd), .redirect_pc(rpc),
    .inst_valid(iv0), .inst_ready(dr), .inst(inst0), .inst_pc(ipc0)
  );

  instruction_fetch #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) u_wrap (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(rv1), .imem_req_ready(mr), .imem_addr(addr1),
    .imem_resp_valid(resp_v1), .imem_resp_data(resp_d1),
    .redirect_valid(rd), .redirect_pc(rpc),
    .inst_valid(iv1), .inst_ready(dr), .inst(inst1), .inst_pc(ipc1)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  typedef struct {
    logic        m_r;
    logic        d_r;
    logic        redir;
    logic [31:0] r_pc;
    logic        e_rv;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_pc;
  } vec_t;

  mreq_t       mq[$];
  int          checks = 0;
  int          errors = 0;
  int          sel, depth_sel, cyc, lat_min, lat_max, n_acc, n_pop;
  logic [31:0] req_exp, dec_exp, first_pop_pc;
  bit          prev_redir, seen_pop;
  logic        s_rv, s_iv;
  logic [31:0] s_addr, s_pc, s_inst;
  vec_t        tbl[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs, present memory response, sample at negedge,
  // run the reference model, then advance to just after the next rising edge.
  task automatic cycle(input logic m_r, input logic d_r, input logic redir, input logic [31:0] r_pc);
    bit          rsp, acc, pp;
    logic [31:0] rdata;
    mreq_t       e;
    mr  = m_r;
    dr  = d_r;
    rd  = redir;
    rpc = r_pc;
    rsp   = (mq.size() > 0) && (mq[0].due <= cyc);
    rdata = rsp ? (mq[0].addr ^ 32'hA5A5_0000) : 32'h0;
    resp_v0 = (sel == 0) && rsp;
    resp_v1 = (sel == 1) && rsp;
    resp_d0 = rdata;
    resp_d1 = rdata;
    @(negedge clk);
    s_rv   = (sel == 1) ? rv1 : rv0;
    s_iv   = (sel == 1) ? iv1 : iv0;
    s_addr = (sel == 1) ? addr1 : addr0;
    s_pc   = (sel == 1) ? ipc1 : ipc0;
    s_inst = (sel == 1) ? inst1 : inst0;
    acc = s_rv && m_r;
    pp  = s_iv && d_r;
    if (prev_redir) check("inst_valid_after_redirect", 32'(s_iv), 32'd0);
    if (redir) check("no_req_on_redirect", 32'(s_rv), 32'd0);
    if (rsp) void'(mq.pop_front());
    if (acc) begin
      check("fetch_addr", s_addr, req_exp);
      check("outstanding_bound", 32'(mq.size() < depth_sel), 32'd1);
      req_exp += 32'd4;
      e.addr = s_addr;
      e.due  = cyc + int'($urandom_range(lat_max, lat_min));
      mq.push_back(e);
      n_acc++;
    end
    if (pp) begin
      check("decode_pc", s_pc, dec_exp);
      check("decode_inst", s_inst, dec_exp ^ 32'hA5A5_0000);
      if (!seen_pop) first_pop_pc = s_pc;
      seen_pop = 1'b1;
      dec_exp += 32'd4;
      n_pop++;
    end
    if (redir) begin
      req_exp = r_pc & 32'hFFFF_FFFC;
      dec_exp = r_pc & 32'hFFFF_FFFC;
    end
    prev_redir = redir;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input int s, input logic [31:0] start_pc, input int lmin, input int lmax);
    sel       = s;
    depth_sel = (s == 1) ? 4 : 2;
    lat_min   = lmin;
    lat_max   = lmax;
    rst_n   = 1'b0;
    mr      = 1'b0;
    dr      = 1'b0;
    rd      = 1'b0;
    rpc     = 32'h0;
    resp_v0 = 1'b0;
    resp_v1 = 1'b0;
    resp_d0 = 32'h0;
    resp_d1 = 32'h0;
    @(negedge clk);
    check("reset_req_valid", 32'((s == 1) ? rv1 : rv0), 32'd0);
    check("reset_inst_valid", 32'((s == 1) ? iv1 : iv0), 32'd0);
    check("reset_addr", (s == 1) ? addr1 : addr0, start_pc);
    check("reset_inst", (s == 1) ? inst1 : inst0, 32'h0);
    check("reset_inst_pc", (s == 1) ? ipc1 : ipc0, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
    mq.delete();
    req_exp    = start_pc;
    dec_exp    = start_pc;
    prev_redir = 1'b0;
    n_acc      = 0;
    n_pop      = 0;
    seen_pop   = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1;
    #2;

    // Stall/drain/redirect timeline for DEPTH=2 with a 1-cycle memory.
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h0,   1'b0, 32'h0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h4,   1'b0, 32'h0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h8,   1'b1, 32'h0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h8,   1'b1, 32'h0};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h8,   1'b1, 32'h0};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h8,   1'b1, 32'h4};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'hC,   1'b0, 32'h0};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h10,  1'b1, 32'h8};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 32'h103, 1'b0, 32'h10,  1'b1, 32'h8};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h0};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h104, 1'b0, 32'h0};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h108, 1'b1, 32'h100};
    tbl[12] = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h108, 1'b1, 32'h104};

    do_reset(0, 32'h0, 1, 1);
    foreach (tbl[i]) begin
      cycle(tbl[i].m_r, tbl[i].d_r, tbl[i].redir, tbl[i].r_pc);
      check("tbl_req_valid", 32'(s_rv), 32'(tbl[i].e_rv));
      check("tbl_addr", s_addr, tbl[i].e_addr);
      check("tbl_inst_valid", 32'(s_iv), 32'(tbl[i].e_iv));
      if (tbl[i].e_iv) check("tbl_inst_pc", s_pc, tbl[i].e_pc);
    end

    // Memory back-pressure: request held stable until accepted.
    do_reset(0, 32'h0, 1, 1);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 32'h0);
      check("stall_req_valid", 32'(s_rv), 32'd1);
      check("stall_addr", s_addr, 32'h0);
    end
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    check("stall_accept", 32'(n_acc), 32'd1);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    check("stall_next_addr", s_addr, 32'h4);

    // 3-cycle memory: two stale responses dropped after redirect.
    do_reset(0, 32'h0, 3, 3);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b1, 32'h0000_0103);
    seen_pop = 1'b0;
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    check("drop2_req_hold_a", 32'(s_rv), 32'd0);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    check("drop2_req_hold_b", 32'(s_rv), 32'd0);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    check("drop2_resume", 32'(s_rv), 32'd1);
    check("drop2_addr", s_addr, 32'h100);
    for (int k = 0; k < 20 && !seen_pop; k++) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    check("drop2_seen_pop", 32'(seen_pop), 32'd1);
    check("drop2_first_pc", first_pop_pc, 32'h100);

    // Redirect coincident with a response and a decode handshake.
    do_reset(0, 32'h0, 1, 1);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b1, 32'h0000_0040);
    check("coinc_handshake_valid", 32'(s_iv), 32'd1);
    check("coinc_handshake_pc", s_pc, 32'h0);
    seen_pop = 1'b0;
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    check("coinc_resume", 32'(s_rv), 32'd1);
    check("coinc_addr", s_addr, 32'h40);
    for (int k = 0; k < 20 && !seen_pop; k++) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    check("coinc_seen_pop", 32'(seen_pop), 32'd1);
    check("coinc_first_pc", first_pop_pc, 32'h40);

    // Redirect with two outstanding and one response arriving: drop becomes 1.
    do_reset(0, 32'h0, 2, 2);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b1, 32'h0000_0082);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    check("drop1_hold", 32'(s_rv), 32'd0);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    check("drop1_resume", 32'(s_rv), 32'd1);
    check("drop1_addr", s_addr, 32'h80);

    // Randomized traffic against the reference model.
    do_reset(0, 32'h0, 1, 4);
    for (int i = 0; i < 3000; i++) begin
      cycle(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 9) < 7),
            logic'($urandom_range(0, 24) == 0), $urandom);
    end
    check("random_progress", 32'(n_pop > 100), 32'd1);

    // DEPTH=4 instance: PC wrap and one instruction per cycle sustained.
    do_reset(1, 32'hFFFF_FFF8, 1, 1);
    for (int i = 0; i < 22; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    check("wrap_accepts", 32'(n_acc), 32'd22);
    check("wrap_sustained_pops", 32'(n_pop), 32'd20);

    // Asynchronous reset mid-stream.
    check("midreset_pre_req", 32'(rv1), 32'd1);
    check("midreset_pre_inst", 32'(iv1), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_req_valid", 32'(rv1), 32'd0);
    check("midreset_inst_valid", 32'(iv1), 32'd0);
    check("midreset_addr", addr1, 32'hFFFF_FFF8);
    mq.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
